// File: rtl/msg_len_accum.sv
// Passive AXI-Stream message length monitor: sums popcount(tkeep) per message and queues
// {len, oversize, runt} results in a FWFT FIFO. Optional statistics via MSG_LEN_ACCUM_STATS_EN.
module msg_len_accum #(
   parameter int TKEEP_WIDTH = 8,
   parameter int LEN_WIDTH   = 16,
   parameter int MAX_LEN     = 1518,
   parameter int MIN_LEN     = 64,
   parameter int RES_DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_tvalid,
   input  logic                   s_tready,
   input  logic                   s_tlast,
   input  logic [TKEEP_WIDTH-1:0] s_tkeep,
   input  logic                   count_en,
   output logic [LEN_WIDTH-1:0]   m_len,
   output logic                   m_oversize,
   output logic                   m_runt,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [7:0]             drop_cnt,
   output logic                   busy
`ifdef MSG_LEN_ACCUM_STATS_EN
  ,output logic [31:0]            stat_msgs,
   output logic [47:0]            stat_bytes
`endif
);

   localparam int PW = $clog2(RES_DEPTH);

   typedef enum logic {S_IDLE, S_ACCUM} state_e;

   typedef struct packed {
      logic [LEN_WIDTH-1:0] len;
      logic                 oversize;
      logic                 runt;
   } result_t;

   function automatic logic [LEN_WIDTH:0] popcount(input logic [TKEEP_WIDTH-1:0] keep);
      logic [LEN_WIDTH:0] cnt;
      cnt = '0;
      for (int i = 0; i < TKEEP_WIDTH; i++) cnt = cnt + (LEN_WIDTH+1)'(keep[i]);
      return cnt;
   endfunction

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] acc_q, acc_d;
   logic                 sat_q, sat_d;
   logic [PW:0]          wr_q, wr_d, rd_q, rd_d;
   logic [7:0]           drop_q, drop_d;
   result_t              mem_q [RES_DEPTH];

   logic                 beat, complete, ovf;
   logic [LEN_WIDTH:0]   total;
   logic [LEN_WIDTH-1:0] len_clamped;
   result_t              res, head;
   logic                 empty, full, pop, push, drop;

   assign beat        = s_tvalid & s_tready & count_en;
   assign complete    = beat & s_tlast;
   // acc_q is always 0 in IDLE, so one adder covers both the first and later beats.
   assign total       = {1'b0, acc_q} + popcount(s_tkeep);
   assign ovf         = total[LEN_WIDTH];
   assign len_clamped = ovf ? '1 : total[LEN_WIDTH-1:0];

   assign res.len      = len_clamped;
   assign res.oversize = (32'(len_clamped) > 32'(MAX_LEN)) | sat_q | ovf;
   assign res.runt     = 32'(len_clamped) < 32'(MIN_LEN);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      if (beat) begin
         if (s_tlast) begin
            state_d = S_IDLE;
            acc_d   = '0;
            sat_d   = 1'b0;
         end else begin
            state_d = S_ACCUM;
            acc_d   = len_clamped;
            sat_d   = sat_q | ovf;
         end
      end
   end

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign pop   = ~empty & m_ready;
   assign push  = complete & (~full | pop);
   assign drop  = complete & full & ~pop;

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      drop_d = drop_q;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         drop_q  <= drop_d;
      end
   end

   // NOTE: FIFO storage is not reset; outputs are masked by empty, so stale entries never show.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[PW-1:0]] <= res;
   end

   assign head       = mem_q[rd_q[PW-1:0]];
   assign m_valid    = ~empty;
   assign m_len      = empty ? '0 : head.len;
   assign m_oversize = ~empty & head.oversize;
   assign m_runt     = ~empty & head.runt;
   assign drop_cnt   = drop_q;
   assign busy       = (state_q == S_ACCUM);

`ifdef MSG_LEN_ACCUM_STATS_EN
   logic [31:0] msgs_q;
   logic [47:0] bytes_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msgs_q  <= '0;
         bytes_q <= '0;
      end else if (complete) begin
         msgs_q  <= msgs_q + 32'd1;
         bytes_q <= bytes_q + 48'(len_clamped);
      end
   end

   assign stat_msgs  = msgs_q;
   assign stat_bytes = bytes_q;
`endif

endmodule
